serial_sub: RTL and testbench

SERIAL_SUB -- requirements
Module: serial_sub

---
 rtl/serial_sub.sv | 96 +++++++++
 tb/tb_serial_sub.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/serial_sub.sv
// Bit-serial subtractor: computes a - b - bin one bit per cycle, LSB first,
// with a registered IDLE/SHIFT/DONE controller and registered outputs.
module serial_sub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-2:0] sr;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             d;
  logic             br_nx;
  logic [WIDTH-1:0] res_nx;

  // Full-subtractor cell; res_nx is the result register after shifting d in
  // at the MSB, so its final value is the complete difference.
  always_comb begin
    d      = sa[0] ^ sb[0] ^ br;
    br_nx  = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    res_nx = {d, sr};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      sa    <= '0;
      sb    <= '0;
      sr    <= '0;
      br    <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            sa    <= a;
            sb    <= b;
            br    <= bin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          sr  <= res_nx[WIDTH-1:1];
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          br  <= br_nx;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            diff  <= res_nx;
            bout  <= br_nx;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Directed and random self-checking bench for serial_sub at WIDTH=8.
module tb_serial_sub;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  serial_sub #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .diff (diff),
    .bout (bout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    a     = av;
    b     = bv;
    bin   = cv;
    start = 1'b1;
  endtask

  // Runs from the accepting edge to the DONE cycle; operands are scrambled
  // after acceptance so any late sampling shows up in the result.
  task automatic finish(input logic [W-1:0] ed, input logic eb, input logic [W-1:0] prev);
    tick();
    start = 1'b0;
    a     = ~a;
    b     = b ^ 8'h5A;
    bin   = ~bin;
    for (int i = 0; i < int'(W); i++) begin
      check("busy", busy, 1);
      check("done_low", done, 0);
      check("diff_hold", diff, prev);
      tick();
    end
    check("done", done, 1);
    check("busy_low", busy, 0);
    check("diff", diff, ed);
    check("bout", bout, eb);
  endtask

  initial begin
    logic [W-1:0] av, bv, prev;
    logic         cv;
    logic [W:0]   r;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff, 0);
    check("rst_bout", bout, 0);
    rst = 1'b0;

    launch(8'h05, 8'h03, 1'b0);
    finish(8'h02, 1'b0, 8'h00);
    tick();
    check("pulse_end", done, 0);
    check("idle_busy", busy, 0);

    launch(8'h00, 8'h01, 1'b0);
    finish(8'hFF, 1'b1, 8'h02);
    tick();
    launch(8'h80, 8'h80, 1'b1);
    finish(8'hFF, 1'b1, 8'hFF);
    tick();

    // start held through SHIFT while operands change
    launch(8'h10, 8'h01, 1'b0);
    tick();
    a = 8'hAA;
    b = 8'h11;
    for (int i = 0; i < int'(W); i++) begin
      check("held_busy", busy, 1);
      check("held_done_low", done, 0);
      tick();
    end
    check("held_done", done, 1);
    check("held_diff", diff, 8'h0F);
    check("held_bout", bout, 0);
    start = 1'b0;
    tick();
    check("held_idle", busy, 0);

    // reset in the 4th SHIFT cycle
    launch(8'h05, 8'h03, 1'b0);
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("pre_rst_busy", busy, 1);
      tick();
    end
    rst = 1'b1;
    tick();
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_diff", diff, 0);
    check("abort_bout", bout, 0);
    start = 1'b1;
    tick();
    check("rst_over_start", busy, 0);
    rst = 1'b0;
    launch(8'h00, 8'h00, 1'b1);
    finish(8'hFF, 1'b1, 8'h00);
    tick();

    // back-to-back accept in the DONE cycle
    launch(8'h20, 8'h05, 1'b0);
    finish(8'h1B, 1'b0, 8'hFF);
    launch(8'h07, 8'h09, 1'b0);
    finish(8'hFE, 1'b1, 8'h1B);
    tick();
    check("b2b_pulse_end", done, 0);

    prev = 8'hFE;
    for (int t = 0; t < 1000; t++) begin
      av = W'($urandom);
      bv = W'($urandom);
      cv = 1'($urandom_range(0, 1));
      r  = {1'b0, av} - {1'b0, bv} - {{W{1'b0}}, cv};
      launch(av, bv, cv);
      finish(r[W-1:0], r[W], prev);
      prev = r[W-1:0];
      if ($urandom_range(0, 1) == 1) begin
        tick();
        check("rnd_pulse_end", done, 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
